// File: rtl/bnn_frame_ctrl_pkg.sv
// Shared types and net16 geometry for the BNN frame sequencing controller.
// Imported by the interface, the argmax scanner and the top bnn_frame_ctrl.
package bnn_ctrl_pkg;

  localparam int NET16_ROWS    = 16;
  localparam int NET16_COLS    = 16;
  localparam int NET16_NCLASS  = 4;
  localparam int NET16_SCORE_W = 7;

  typedef logic [NET16_NCLASS-1:0][NET16_SCORE_W-1:0] score_vec_t;

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    SCAN,
    OUT
  } ctrl_state_e;

endpackage

// File: rtl/bnn_frame_ctrl_if.sv
// Row-stream and result handshakes of bnn_frame_ctrl bundled as one interface.
// The slave modport is the controller side; master is the producer/consumer side.
interface bnn_frame_ctrl_if
  import bnn_ctrl_pkg::*;
#(
  parameter int COLS    = NET16_COLS,
  parameter int N_CLASS = NET16_NCLASS,
  parameter int SCORE_W = NET16_SCORE_W,
  parameter int CLASS_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
);

  logic                            row_valid_i;
  logic                            row_ready_o;
  logic [COLS-1:0]                 row_data_i;
  logic                            res_valid_o;
  logic                            res_ready_i;
  logic [N_CLASS-1:0][SCORE_W-1:0] res_scores_o;
  logic [CLASS_W-1:0]              res_class_o;

  modport slave (
    input  row_valid_i, row_data_i, res_ready_i,
    output row_ready_o, res_valid_o, res_scores_o, res_class_o
  );

  modport master (
    output row_valid_i, row_data_i, res_ready_i,
    input  row_ready_o, res_valid_o, res_scores_o, res_class_o
  );

endinterface

// File: rtl/bnn_frame_ctrl_argmax_seq.sv
// Sequential argmax: while run_i is high, examines one score per cycle and
// publishes the winning index when the last score has been examined.
module bnn_argmax_seq
  import bnn_ctrl_pkg::*;
#(
  parameter int N_CLASS = NET16_NCLASS,
  parameter int SCORE_W = NET16_SCORE_W,
  parameter int CLASS_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  input  logic                            run_i,
  input  logic [N_CLASS-1:0][SCORE_W-1:0] scores_i,
  output logic                            done_o,
  output logic [CLASS_W-1:0]              class_o
);

  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(N_CLASS - 1);

  logic [CLASS_W-1:0] idx_q, idx_d;
  logic [CLASS_W-1:0] best_idx_q, best_idx_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [CLASS_W-1:0] class_q, class_d;
  logic [SCORE_W-1:0] cand;
  logic               take;

  // Index 0 always seeds the running best; later ones need strictly greater,
  // so ties stay with the lowest index.
  always_comb begin
    cand       = scores_i[idx_q];
    take       = (idx_q == '0) || (cand > best_q);
    done_o     = run_i && (idx_q == LAST_IDX);
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    class_d    = class_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (run_i) begin
      if (take) begin
        best_d     = cand;
        best_idx_d = idx_q;
      end
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        class_d = take ? idx_q : best_idx_q;
      end else begin
        idx_d = idx_q + CLASS_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
    end else begin
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      class_q    <= class_d;
    end
  end

  assign class_o = class_q;

endmodule

// File: rtl/bnn_frame_ctrl.sv
// Frame sequencer for the combinational net16 BNN: load rows, settle, scan, return.
// Optional frame counter on perf_frames_o enabled by BNN_FRAME_CTRL_PERF_EN.
module bnn_frame_ctrl
  import bnn_ctrl_pkg::*;
#(
  parameter int ROWS          = NET16_ROWS,
  parameter int COLS          = NET16_COLS,
  parameter int N_CLASS       = NET16_NCLASS,
  parameter int SCORE_W       = NET16_SCORE_W,
  parameter int SETTLE_CYCLES = 4,
  parameter int CLASS_W       = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  bnn_frame_ctrl_if.slave                 bus_if,
  output logic [0:0][ROWS-1:0][COLS-1:0]  net_frame_o,
  input  logic [N_CLASS-1:0][SCORE_W-1:0] net_scores_i,
  output logic                            cfg_lock_o,
  output logic                            busy_o,
  output logic [15:0]                     perf_frames_o
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(ROWS - 1);
  localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);

  ctrl_state_e                     state_q, state_d;
  logic [ROW_W-1:0]                row_cnt_q, row_cnt_d;
  logic [SET_W-1:0]                settle_q, settle_d;
  logic [ROWS-1:0][COLS-1:0]       frame_q, frame_d;
  logic [N_CLASS-1:0][SCORE_W-1:0] scores_q, scores_d;
  logic                            row_ready, row_fire;
  logic                            res_valid, res_fire;
  logic                            scan_run, scan_done;
  logic [CLASS_W-1:0]              class_w;

  assign row_ready = (state_q == LOAD) && !clear_i;
  assign row_fire  = row_ready && bus_if.row_valid_i;
  assign res_valid = (state_q == OUT);
  assign res_fire  = res_valid && bus_if.res_ready_i && !clear_i;
  assign scan_run  = (state_q == SCAN);

  // clear_i overrides every transition but leaves the frame and captured scores intact.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    settle_d  = settle_q;
    frame_d   = frame_q;
    scores_d  = scores_q;
    unique case (state_q)
      LOAD: begin
        if (row_fire) begin
          frame_d[row_cnt_q] = bus_if.row_data_i;
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d = '0;
            state_d   = SETTLE;
          end else begin
            row_cnt_d = row_cnt_q + ROW_W'(1);
          end
        end
      end
      SETTLE: begin
        if (settle_q == LAST_SETTLE) begin
          settle_d = '0;
          scores_d = net_scores_i;
          state_d  = SCAN;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      SCAN: begin
        if (scan_done) state_d = OUT;
      end
      OUT: begin
        if (res_fire) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    if (clear_i) begin
      state_d   = LOAD;
      row_cnt_d = '0;
      settle_d  = '0;
      frame_d   = frame_q;
      scores_d  = scores_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= LOAD;
      row_cnt_q <= '0;
      settle_q  <= '0;
      frame_q   <= '0;
      scores_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      settle_q  <= settle_d;
      frame_q   <= frame_d;
      scores_q  <= scores_d;
    end
  end

  bnn_argmax_seq #(
    .N_CLASS (N_CLASS),
    .SCORE_W (SCORE_W),
    .CLASS_W (CLASS_W)
  ) u_argmax (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (clear_i),
    .run_i    (scan_run),
    .scores_i (scores_q),
    .done_o   (scan_done),
    .class_o  (class_w)
  );

  assign bus_if.row_ready_o  = row_ready;
  assign bus_if.res_valid_o  = res_valid;
  assign bus_if.res_scores_o = scores_q;
  assign bus_if.res_class_o  = class_w;
  assign net_frame_o[0]      = frame_q;
  assign cfg_lock_o          = (state_q == SETTLE) || (state_q == SCAN);
  assign busy_o              = (state_q != LOAD);

`ifdef BNN_FRAME_CTRL_PERF_EN
  logic [15:0] perf_q;

  // Saturating count of consumed results; only a hard reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (res_fire && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_frames_o = perf_q;
`else
  assign perf_frames_o = '0;
`endif

endmodule
